mem_port_scheduler: RTL and testbench
=====================================

MEM_PORT_SCHEDULER -- requirements
Module: mem_port_scheduler

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 3, cycles from store issue to store completion.
REQ-002 SHALL have parameter SB_DEPTH, default 4, store-buffer entries (power of two).
REQ-003 SHALL have ports: clk  in  1  single clock, all state on rising edge; reset  in  1  asynchronous, active-high.
REQ-004 SHALL have store-request ports: st_valid in 1 retired store offered; st_ready out 1 store accepted when both high; st_addr in 32; st_data in 32; st_BMS in 1 (1=byte, 0=word).
REQ-005 SHALL have load-request ports: ld_valid in 1; ld_ready out 1; ld_addr in 32; ld_BMS in 1; ld_tag in 6 rd tag.
REQ-006 SHALL have memory ports: mem_address out 32; mem_store_value out 32; mem_BMS out 1; mem_LS out 1 (1=load, 0=store); mem_valid out 1 one-cycle issue strobe; mem_load_value_out in 32; mem_valid_out in 1 load-data strobe.
REQ-007 SHALL have response ports: ld_resp_valid out 1; ld_resp_tag out 6; ld_resp_value out 32; busy out 1 (state not IDLE or buffer non-empty or load held).

Function
REQ-008 SHALL buffer accepted stores in a FIFO of SB_DEPTH entries {addr, data, BMS}, drained strictly in order.
REQ-009 SHALL drive st_ready = 1 iff registered entry count < SB_DEPTH; a pop in the same cycle does not raise st_ready that cycle.
REQ-010 SHALL hold at most one load in a holding register; ld_ready = 1 iff holding register empty.
REQ-011 SHALL implement FSM states IDLE, ST_WAIT, LD_WAIT, LD_RESP.
REQ-012 In IDLE, arbitration SHALL be: (a) buffer full -> issue head store; else (b) load held and no hazard -> issue load; else (c) buffer non-empty -> issue head store; else stay IDLE.
REQ-013 Hazard SHALL be: held load addr[31:2] equals addr[31:2] of any valid buffer entry; hazardous load waits until all matching stores drain.
REQ-014 Store issue SHALL assert mem_valid=1 for exactly one cycle with mem_LS=0, mem_address/mem_store_value/mem_BMS from head entry, pop the entry, load counter with MEM_LATENCY-1, enter ST_WAIT.
REQ-015 ST_WAIT SHALL decrement counter each cycle and return to IDLE the cycle after counter reaches 0; next issue no earlier than MEM_LATENCY cycles after previous store strobe.
REQ-016 Load issue SHALL assert mem_valid=1 for one cycle with mem_LS=1, mem_address=held addr, mem_BMS=held BMS, enter LD_WAIT.
REQ-017 LD_WAIT SHALL wait indefinitely for mem_valid_out=1, then register data and enter LD_RESP.
REQ-018 LD_RESP SHALL assert ld_resp_valid=1 for exactly one cycle with ld_resp_tag=held tag; ld_resp_value = {24'b0, data[7:0]} if held BMS=1, else data; SHALL clear holding register and return to IDLE.
REQ-019 mem_valid_out SHALL be ignored in any state other than LD_WAIT.
REQ-020 mem_valid and ld_resp_valid SHALL be 0 in every cycle not specified above; other outputs hold last value.
REQ-021 Buffer pointers SHALL wrap modulo SB_DEPTH; simultaneous push and pop SHALL leave count unchanged.
REQ-022 A load SHALL be accepted in the same cycle its predecessor's LD_RESP completes only on the following cycle (ld_ready from registered state).

Reset
REQ-023 reset=1 SHALL immediately force state IDLE, counter 0, buffer count/pointers 0, holding register empty, all outputs 0 except st_ready=1, ld_ready=1.
REQ-024 Reset mid-operation SHALL discard buffered stores and held load; no response SHALL be produced for them.

Verification
REQ-025 Single store addr=0x100 data=0xDEADBEEF, MEM_LATENCY=3 -> one mem_valid cycle, mem_LS=0, values match; busy drops 3 cycles after strobe.
REQ-026 Five back-to-back stores, SB_DEPTH=4 -> st_ready low after 4 accepted; stores issued in order; 5th accepted after first pop.
REQ-027 Store to 0x200 buffered, load 0x202 word tag 5 -> load issued only after store strobe; ld_resp_tag=5.
REQ-028 Load 0x300 BMS=1, memory returns 0x12345678 -> ld_resp_value=0x00000078, one-cycle ld_resp_valid.
REQ-029 Load held plus 2 non-conflicting stores -> load issued first; then stores; full buffer with held load -> store first.
REQ-030 reset asserted in LD_WAIT, then mem_valid_out pulsed -> no ld_resp_valid, all outputs at reset values.

Source files
------------

// File: rtl/mem_port_scheduler.sv
// Memory port scheduler: a store buffer and a single held load share one
// memory port. Full buffers drain first, then loads that do not alias a
// buffered store, then any remaining stores. The strobes mem_valid and
// ld_resp_valid are registered one-cycle pulses. The other memory and
// response outputs are registered and keep their last value.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | arbitrate between the store buffer head and the held load
// ST_WAIT | store in flight, latency counter running down to zero
// LD_WAIT | load in flight, waiting for mem_valid_out
// LD_RESP | response pulse cycle, holding register released at its end
`timescale 1ns/1ps
module mem_port_scheduler #(
  parameter int MEM_LATENCY = 3,
  parameter int SB_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic        st_BMS,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_addr,
  input  logic        ld_BMS,
  input  logic [5:0]  ld_tag,
  output logic [31:0] mem_address,
  output logic [31:0] mem_store_value,
  output logic        mem_BMS,
  output logic        mem_LS,
  output logic        mem_valid,
  input  logic [31:0] mem_load_value_out,
  input  logic        mem_valid_out,
  output logic        ld_resp_valid,
  output logic [5:0]  ld_resp_tag,
  output logic [31:0] ld_resp_value,
  output logic        busy
);

  localparam int PW   = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
  localparam int CNTW = PW + 1;
  localparam int CW   = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ST_WAIT, LD_WAIT, LD_RESP} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   wait_cnt;

  logic [31:0]     sb_addr [SB_DEPTH];
  logic [31:0]     sb_data [SB_DEPTH];
  logic            sb_bms  [SB_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CNTW-1:0] sb_count;
  logic            sb_full;

  logic            ld_held;
  logic [31:0]     ld_addr_q;
  logic            ld_bms_q;
  logic [5:0]      ld_tag_q;

  logic            st_push, ld_accept, hazard;
  logic            issue_st, issue_ld, ld_capture, ld_done;

  // Handshakes come from registered state only, so a same-cycle pop or
  // response never opens the input early.
  assign st_ready  = (sb_count < CNTW'(SB_DEPTH));
  assign ld_ready  = ~ld_held;
  assign st_push   = st_valid & st_ready;
  assign ld_accept = ld_valid & ld_ready;
  assign sb_full   = (sb_count == CNTW'(SB_DEPTH));
  assign busy      = (state != IDLE) | (sb_count != '0) | ld_held;

  // A held load aliases any live buffer entry on the same 32-bit word.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if ((CNTW'(i) < sb_count) &&
          (sb_addr[rd_ptr + PW'(i)][31:2] == ld_addr_q[31:2]))
        hazard = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic and issue/response decisions.
  always_comb begin
    state_nxt  = state;
    issue_st   = 1'b0;
    issue_ld   = 1'b0;
    ld_capture = 1'b0;
    ld_done    = 1'b0;
    case (state)
      IDLE: begin
        if (sb_full) begin
          issue_st  = 1'b1;
          state_nxt = ST_WAIT;
        end else if (ld_held && !hazard) begin
          issue_ld  = 1'b1;
          state_nxt = LD_WAIT;
        end else if (sb_count != '0) begin
          issue_st  = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: if (wait_cnt == '0) state_nxt = IDLE;
      LD_WAIT: begin
        if (mem_valid_out) begin
          ld_capture = 1'b1;
          state_nxt  = LD_RESP;
        end
      end
      LD_RESP: begin
        ld_done   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Store latency down-counter, reloaded on every store issue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   wait_cnt <= '0;
    else if (issue_st)                           wait_cnt <= CW'(MEM_LATENCY - 1);
    else if (state == ST_WAIT && wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
  end

  // Buffer payload; validity is tracked by the count, so no reset needed.
  always_ff @(posedge clk) begin
    if (st_push) begin
      sb_addr[wr_ptr] <= st_addr;
      sb_data[wr_ptr] <= st_data;
      sb_bms[wr_ptr]  <= st_BMS;
    end
  end

  // Buffer pointers and occupancy; pointers wrap at the power-of-two depth.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      sb_count <= '0;
    end else begin
      if (st_push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue_st) rd_ptr <= rd_ptr + 1'b1;
      if (st_push && !issue_st)      sb_count <= sb_count + 1'b1;
      else if (!st_push && issue_st) sb_count <= sb_count - 1'b1;
    end
  end

  // Load holding register, released at the end of the response cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_held   <= 1'b0;
      ld_addr_q <= '0;
      ld_bms_q  <= 1'b0;
      ld_tag_q  <= '0;
    end else if (ld_done) begin
      ld_held <= 1'b0;
    end else if (ld_accept) begin
      ld_held   <= 1'b1;
      ld_addr_q <= ld_addr;
      ld_bms_q  <= ld_BMS;
      ld_tag_q  <= ld_tag;
    end
  end

  // Registered memory-side outputs; strobe pulses for the issue cycle only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_valid       <= 1'b0;
      mem_address     <= '0;
      mem_store_value <= '0;
      mem_BMS         <= 1'b0;
      mem_LS          <= 1'b0;
    end else begin
      mem_valid <= issue_st | issue_ld;
      if (issue_st) begin
        mem_address     <= sb_addr[rd_ptr];
        mem_store_value <= sb_data[rd_ptr];
        mem_BMS         <= sb_bms[rd_ptr];
        mem_LS          <= 1'b0;
      end else if (issue_ld) begin
        mem_address <= ld_addr_q;
        mem_BMS     <= ld_bms_q;
        mem_LS      <= 1'b1;
      end
    end
  end

  // Registered load response; byte loads are zero-extended from bits [7:0].
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_resp_valid <= 1'b0;
      ld_resp_tag   <= '0;
      ld_resp_value <= '0;
    end else begin
      ld_resp_valid <= ld_capture;
      if (ld_capture) begin
        ld_resp_tag   <= ld_tag_q;
        ld_resp_value <= ld_bms_q ? {24'b0, mem_load_value_out[7:0]}
                                  : mem_load_value_out;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_scheduler.sv
// Directed bench for mem_port_scheduler (MEM_LATENCY=3, SB_DEPTH=4).
// Inputs change and outputs are sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_mem_port_scheduler;

  logic        clk, reset;
  logic        st_valid, st_ready, st_BMS;
  logic [31:0] st_addr, st_data;
  logic        ld_valid, ld_ready, ld_BMS;
  logic [31:0] ld_addr;
  logic [5:0]  ld_tag;
  logic [31:0] mem_address, mem_store_value, mem_load_value_out;
  logic        mem_BMS, mem_LS, mem_valid, mem_valid_out;
  logic        ld_resp_valid, busy;
  logic [5:0]  ld_resp_tag;
  logic [31:0] ld_resp_value;

  int checks   = 0;
  int failures = 0;
  int w;
  int found;

  mem_port_scheduler #(.MEM_LATENCY(3), .SB_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_data(st_data), .st_BMS(st_BMS),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
    .ld_BMS(ld_BMS), .ld_tag(ld_tag),
    .mem_address(mem_address), .mem_store_value(mem_store_value),
    .mem_BMS(mem_BMS), .mem_LS(mem_LS), .mem_valid(mem_valid),
    .mem_load_value_out(mem_load_value_out), .mem_valid_out(mem_valid_out),
    .ld_resp_valid(ld_resp_valid), .ld_resp_tag(ld_resp_tag),
    .ld_resp_value(ld_resp_value), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Offer one store and hold it until accepted; returns cycles spent not ready.
  task automatic push_store(input logic [31:0] a, input logic [31:0] d, input logic b,
                            input int max, output int waited);
    st_valid = 1'b1; st_addr = a; st_data = d; st_BMS = b;
    waited = 0;
    while (!st_ready && waited < max) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    st_valid = 1'b0;
  endtask

  // Advance falling edges until a memory strobe is seen or the budget runs out.
  task automatic wait_strobe(input int max, output int hit);
    hit = 0;
    for (int c = 0; c < max; c++) begin
      if (mem_valid === 1'b1) begin
        hit = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Called on the load strobe edge: stall one cycle, return data, check response.
  task automatic ld_respond(input logic [31:0] data, input logic [5:0] tag_exp,
                            input logic [31:0] val_exp);
    @(negedge clk);
    check("resp_wait_quiet", 32'(ld_resp_valid), 32'd0);
    mem_valid_out = 1'b1;
    mem_load_value_out = data;
    @(negedge clk);
    mem_valid_out = 1'b0;
    check("resp_valid", 32'(ld_resp_valid), 32'd1);
    check("resp_tag", 32'(ld_resp_tag), 32'(tag_exp));
    check("resp_value", ld_resp_value, val_exp);
    check("resp_ld_ready_held", 32'(ld_ready), 32'd0);
    @(negedge clk);
    check("resp_one_cycle", 32'(ld_resp_valid), 32'd0);
    check("resp_ld_ready_free", 32'(ld_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    st_valid = 1'b0; st_addr = '0; st_data = '0; st_BMS = 1'b0;
    ld_valid = 1'b0; ld_addr = '0; ld_BMS = 1'b0; ld_tag = '0;
    mem_load_value_out = '0; mem_valid_out = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_st_ready", 32'(st_ready), 32'd1);
    check("rst_ld_ready", 32'(ld_ready), 32'd1);
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_resp_valid", 32'(ld_resp_valid), 32'd0);
    check("rst_mem_address", mem_address, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single store; busy clears three cycles after the strobe
    push_store(32'h100, 32'hDEADBEEF, 1'b0, 8, w);
    check("t2_push_wait", 32'(w), 32'd0);
    wait_strobe(10, found);
    check("t2_strobe_found", 32'(found), 32'd1);
    check("t2_ls", 32'(mem_LS), 32'd0);
    check("t2_addr", mem_address, 32'h100);
    check("t2_data", mem_store_value, 32'hDEADBEEF);
    check("t2_bms", 32'(mem_BMS), 32'd0);
    @(negedge clk);
    check("t2_strobe_one_cycle", 32'(mem_valid), 32'd0);
    check("t2_busy_p1", 32'(busy), 32'd1);
    mem_valid_out = 1'b1;
    mem_load_value_out = 32'h55555555;
    @(negedge clk);
    mem_valid_out = 1'b0;
    check("t2_busy_p2", 32'(busy), 32'd1);
    @(negedge clk);
    check("t2_busy_p3", 32'(busy), 32'd0);
    check("t2_stray_data_ignored", 32'(ld_resp_valid), 32'd0);
    check("t2_addr_holds", mem_address, 32'h100);

    // Fill the buffer behind a stalled load, then full-buffer store beats a held load
    ld_valid = 1'b1; ld_addr = 32'h400; ld_BMS = 1'b0; ld_tag = 6'd1;
    @(negedge clk);
    ld_valid = 1'b0;
    wait_strobe(10, found);
    check("t3_ld1_found", 32'(found), 32'd1);
    check("t3_ld1_ls", 32'(mem_LS), 32'd1);
    check("t3_ld1_addr", mem_address, 32'h400);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      push_store(32'h1000 + 32'(i * 4), 32'hA5A50000 + 32'(i), (i == 2), 8, w);
      check("t3_push_wait", 32'(w), 32'd0);
    end
    check("t3_full_ready_low", 32'(st_ready), 32'd0);
    st_valid = 1'b1; st_addr = 32'h1010; st_data = 32'hA5A50004; st_BMS = 1'b0;
    ld_respond(32'hCAFEF00D, 6'd1, 32'hCAFEF00D);
    check("t3_still_full", 32'(st_ready), 32'd0);
    ld_valid = 1'b1; ld_addr = 32'h2000; ld_BMS = 1'b0; ld_tag = 6'd3;
    @(negedge clk);
    ld_valid = 1'b0;
    check("t3_s0_strobe", 32'(mem_valid), 32'd1);
    check("t3_s0_ls", 32'(mem_LS), 32'd0);
    check("t3_s0_addr", mem_address, 32'h1000);
    check("t3_s0_data", mem_store_value, 32'hA5A50000);
    check("t3_ready_after_pop", 32'(st_ready), 32'd1);
    check("t3_ld2_held", 32'(ld_ready), 32'd0);
    @(negedge clk);
    st_valid = 1'b0;
    check("t3_fifth_accepted", 32'(st_ready), 32'd0);
    wait_strobe(10, found);
    check("t3_s1_found", 32'(found), 32'd1);
    check("t3_s1_ls", 32'(mem_LS), 32'd0);
    check("t3_s1_addr", mem_address, 32'h1004);
    @(negedge clk);
    wait_strobe(10, found);
    check("t3_ld2_found", 32'(found), 32'd1);
    check("t3_ld2_ls", 32'(mem_LS), 32'd1);
    check("t3_ld2_addr", mem_address, 32'h2000);
    ld_respond(32'h0BADF00D, 6'd3, 32'h0BADF00D);
    for (int i = 2; i < 5; i++) begin
      wait_strobe(10, found);
      check("t3_sn_found", 32'(found), 32'd1);
      check("t3_sn_ls", 32'(mem_LS), 32'd0);
      check("t3_sn_addr", mem_address, 32'h1000 + 32'(i * 4));
      check("t3_sn_data", mem_store_value, 32'hA5A50000 + 32'(i));
      check("t3_sn_bms", 32'(mem_BMS), 32'(i == 2));
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check("t3_idle", 32'(busy), 32'd0);

    // Load aliasing a buffered store waits for the store strobe
    st_valid = 1'b1; st_addr = 32'h200; st_data = 32'h11111111; st_BMS = 1'b0;
    ld_valid = 1'b1; ld_addr = 32'h202; ld_BMS = 1'b0; ld_tag = 6'd5;
    @(negedge clk);
    st_valid = 1'b0; ld_valid = 1'b0;
    wait_strobe(10, found);
    check("t4_store_found", 32'(found), 32'd1);
    check("t4_store_first", 32'(mem_LS), 32'd0);
    check("t4_store_addr", mem_address, 32'h200);
    @(negedge clk);
    wait_strobe(10, found);
    check("t4_load_found", 32'(found), 32'd1);
    check("t4_load_ls", 32'(mem_LS), 32'd1);
    check("t4_load_addr", mem_address, 32'h202);
    ld_respond(32'hAABBCCDD, 6'd5, 32'hAABBCCDD);
    repeat (2) @(negedge clk);

    // Byte load zero-extends the low byte
    ld_valid = 1'b1; ld_addr = 32'h300; ld_BMS = 1'b1; ld_tag = 6'd9;
    @(negedge clk);
    ld_valid = 1'b0;
    wait_strobe(10, found);
    check("t5_found", 32'(found), 32'd1);
    check("t5_ls", 32'(mem_LS), 32'd1);
    check("t5_bms", 32'(mem_BMS), 32'd1);
    check("t5_addr", mem_address, 32'h300);
    ld_respond(32'h12345678, 6'd9, 32'h00000078);
    repeat (2) @(negedge clk);

    // Held load with non-aliasing stores goes first
    ld_valid = 1'b1; ld_addr = 32'h500; ld_BMS = 1'b0; ld_tag = 6'd2;
    st_valid = 1'b1; st_addr = 32'h600; st_data = 32'h66; st_BMS = 1'b0;
    @(negedge clk);
    ld_valid = 1'b0; st_addr = 32'h700; st_data = 32'h77;
    @(negedge clk);
    st_valid = 1'b0;
    wait_strobe(10, found);
    check("t6_load_found", 32'(found), 32'd1);
    check("t6_load_first", 32'(mem_LS), 32'd1);
    check("t6_load_addr", mem_address, 32'h500);
    ld_respond(32'h01020304, 6'd2, 32'h01020304);
    wait_strobe(10, found);
    check("t6_sa_ls", 32'(mem_LS), 32'd0);
    check("t6_sa_addr", mem_address, 32'h600);
    @(negedge clk);
    wait_strobe(10, found);
    check("t6_sb_ls", 32'(mem_LS), 32'd0);
    check("t6_sb_addr", mem_address, 32'h700);
    check("t6_sb_data", mem_store_value, 32'h77);
    repeat (4) @(negedge clk);

    // Reset during LD_WAIT discards the load and a buffered store
    ld_valid = 1'b1; ld_addr = 32'h800; ld_BMS = 1'b0; ld_tag = 6'd7;
    @(negedge clk);
    ld_valid = 1'b0;
    wait_strobe(10, found);
    check("t7_load_found", 32'(found), 32'd1);
    @(negedge clk);
    push_store(32'h900, 32'h99999999, 1'b0, 8, w);
    check("t7_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("t7_rst_mem_addr", mem_address, 32'd0);
    check("t7_rst_mem_ls", 32'(mem_LS), 32'd0);
    check("t7_rst_busy", 32'(busy), 32'd0);
    check("t7_rst_st_ready", 32'(st_ready), 32'd1);
    check("t7_rst_ld_ready", 32'(ld_ready), 32'd1);
    @(negedge clk);
    mem_valid_out = 1'b1;
    mem_load_value_out = 32'hFFFFFFFF;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      mem_valid_out = 1'b0;
      check("t7_no_resp", 32'(ld_resp_valid), 32'd0);
      check("t7_no_issue", 32'(mem_valid), 32'd0);
    end
    check("t7_busy_after", 32'(busy), 32'd0);
    check("t7_resp_value", ld_resp_value, 32'd0);
    check("t7_resp_tag", 32'(ld_resp_tag), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
